ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Drives open-drain PS/2 clock/data lines to send a two-byte command packet (command byte, then argument byte) to the keyboard, e.g. the typematic-rate packet issued on zoom change.
- Consumes the {command, data} packet and send strobe from the main control block.
- Confirms each byte via the device line-ACK bit and the 0xFA response byte, taken from the existing PS/2 receiver.
- Retries on 0xFE (resend) and reports completion or error.

Parameters:
INHIBIT_CYCLES, 5000, clocks the PS/2 clock line is held low before start (100 us at 50 MHz)
TIMEOUT_CYCLES, 1000000, max clocks spent waiting for any device clock edge or response byte (20 ms at 50 MHz)
MAX_RETRY, 2, resend attempts per byte after 0xFE before error

Ports:
clk  input  1  system clock
rst_b  input  1  reset; asynchronous, active-low
ps2_pkt_HD  input  16  packet; [15:8] command byte sent first, [7:0] argument byte sent second
send_ps2_pkt  input  1  1-cycle request; accepted only in IDLE
ps2_clk_in  input  1  raw PS/2 clock line (asynchronous)
ps2_data_in  input  1  raw PS/2 data line (asynchronous)
rx_data  input  8  byte from PS/2 receiver
rx_valid  input  1  1-cycle strobe, rx_data valid
ps2_clk_drive_low  output  1  1 = pull clock line low, 0 = release
ps2_data_drive_low  output  1  1 = pull data line low, 0 = release
busy  output  1  high from accept until done/err
done  output  1  1-cycle pulse, both bytes acknowledged with 0xFA
err  output  1  1-cycle pulse, transfer aborted
err_code  output  2  valid with err: 01 timeout, 10 missing line ACK, 11 retries exhausted or unexpected response byte

Behaviour:
- Reset (async, any state): both drive_low = 0 (lines released), busy = done = err = 0, err_code = 0, state IDLE, all counters 0.
- ps2_clk_in and ps2_data_in pass through 2-flop synchronizers. A falling edge is sync_clk 1 -> 0 between consecutive cycles.
- IDLE: on send_ps2_pkt, latch ps2_pkt_HD, byte_sel = 0, retry = 0, busy = 1 next cycle, go INHIBIT. send_ps2_pkt while busy is ignored; the latched packet is unchanged.
- INHIBIT: clk_drive_low = 1 for exactly INHIBIT_CYCLES clocks, then go REQ.
- REQ: one cycle with clk_drive_low = 1 and data_drive_low = 1 (start bit), then go SHIFT. In SHIFT, clock is released and data is held low.
- Current byte in SHIFT: latched[15:8] when byte_sel = 0, otherwise latched[7:0]. bit_cnt starts at 0.
- SHIFT: on each device falling edge, update data_drive_low, then increment bit_cnt:
  - bit_cnt 0..7: data_drive_low = ~byte[bit_cnt] (LSB first).
  - bit_cnt 8: data_drive_low = ~parity, where parity = ~^byte (odd parity).
  - bit_cnt 9: data_drive_low = 0 (stop bit, line released), go LACK.
- LACK: on the next falling edge, sample sync_data. 0 -> go RESP. 1 -> err, code 10.
- RESP: wait for rx_valid.
  - 0xFA: if byte_sel = 0, set byte_sel = 1, retry = 0, go INHIBIT. Otherwise pulse done, go IDLE.
  - 0xFE: if retry < MAX_RETRY, increment retry and go INHIBIT with the same byte. Otherwise err, code 11.
  - Any other byte: err, code 11.
- rx_valid outside RESP is ignored.
- Timeout: a counter clears on state entry and on every falling edge. It runs only in SHIFT, LACK and RESP. Reaching TIMEOUT_CYCLES gives err, code 01.
- Any error: drive_low outputs release in the same cycle state returns to IDLE. err is pulsed with err_code. busy deasserts with the done/err pulse.
- Outputs are registered.
- err_code holds its last value until the next err.
- done and err are never both high.

Test Plan:
- ps2_pkt_HD = 16'hF300, send pulse; device model clocks and returns 0xFA after each byte.
  - Required: clock held low 5000 cycles before each byte.
  - Required: byte 1 bits = 1,1,0,0,1,1,1,1, parity 1; byte 2 = eight 0s, parity 1.
  - Required: done pulses once, busy low after, no err.
- Device answers 0xFE to the first byte, then 0xFA.
  - Required: byte 0xF3 is retransmitted, including a new inhibit.
  - Required: the transfer then completes with done.
- Device answers 0xFE three times (MAX_RETRY = 2).
  - Required: exactly 3 transmissions of 0xF3, then err with err_code = 11, lines released.
- Device leaves data high at the 11th falling edge.
  - Required: err with code 10, no RESP wait.
- Device stops clocking after bit 4.
  - Required: err with code 01 exactly TIMEOUT_CYCLES after the last falling edge.
  - Required: second send_ps2_pkt during this transfer is ignored.
- rst_b asserted mid-SHIFT.
  - Required: both drive_low = 0 immediately (asynchronous), busy = 0.
  - Required: a new send after reset transmits cleanly.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends a command byte then an argument byte,
// confirms each one with the device line ACK and a 0xFA reply, retries on 0xFE.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRY      = 2
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [15:0] ps2_pkt_HD,
    input  logic        send_ps2_pkt,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        ps2_clk_drive_low,
    output logic        ps2_data_drive_low,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int CMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                          INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RET_MAX  = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_LACK, S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     pkt_q, pkt_d;
    logic            sel_q, sel_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [3:0]      bit_q, bit_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            clk_dl_q, clk_dl_d;
    logic            data_dl_q, data_dl_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [1:0]      code_q, code_d;

    logic [1:0]      clk_sync_q, data_sync_q;
    logic            clk_prev_q;
    logic            fall, sdata, timed, to_hit, fail;
    logic [1:0]      fail_code;
    logic [7:0]      cur_byte;
    logic            parity;

    assign fall     = clk_prev_q & ~clk_sync_q[1];
    assign sdata    = data_sync_q[1];
    assign cur_byte = sel_q ? pkt_q[7:0] : pkt_q[15:8];
    assign parity   = ~^cur_byte;
    assign timed    = (state_q == S_SHIFT) || (state_q == S_LACK) ||
                      (state_q == S_RESP);
    assign to_hit   = (cnt_q == TO_LAST);

    // Two-flop synchronizers for the raw lines plus the edge-detect history.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
            clk_prev_q  <= clk_sync_q[1];
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= S_IDLE;
            pkt_q     <= '0;
            sel_q     <= 1'b0;
            retry_q   <= '0;
            bit_q     <= '0;
            cnt_q     <= '0;
            clk_dl_q  <= 1'b0;
            data_dl_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            pkt_q     <= pkt_d;
            sel_q     <= sel_d;
            retry_q   <= retry_d;
            bit_q     <= bit_d;
            cnt_q     <= cnt_d;
            clk_dl_q  <= clk_dl_d;
            data_dl_q <= data_dl_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            code_q    <= code_d;
        end
    end

    // Next-state, line drive and handshake logic.
    always_comb begin
        state_d   = state_q;
        pkt_d     = pkt_q;
        sel_d     = sel_q;
        retry_d   = retry_q;
        bit_d     = bit_q;
        clk_dl_d  = clk_dl_q;
        data_dl_d = data_dl_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        code_d    = code_q;
        fail      = 1'b0;
        fail_code = 2'b00;

        unique case (state_q)
            S_IDLE: begin
                if (send_ps2_pkt) begin
                    pkt_d     = ps2_pkt_HD;
                    sel_d     = 1'b0;
                    retry_d   = '0;
                    busy_d    = 1'b1;
                    clk_dl_d  = 1'b1;
                    data_dl_d = 1'b0;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    data_dl_d = 1'b1;
                    bit_d     = '0;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                clk_dl_d = 1'b0;
                state_d  = S_SHIFT;
            end
            S_SHIFT: begin
                if (fall) begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q < 4'd8) begin
                        data_dl_d = ~cur_byte[bit_q[2:0]];
                    end else if (bit_q == 4'd8) begin
                        data_dl_d = ~parity;
                    end else begin
                        data_dl_d = 1'b0;
                        state_d   = S_LACK;
                    end
                end else if (to_hit) begin
                    fail      = 1'b1;
                    fail_code = 2'b01;
                end
            end
            S_LACK: begin
                if (fall) begin
                    if (!sdata) begin
                        state_d = S_RESP;
                    end else begin
                        fail      = 1'b1;
                        fail_code = 2'b10;
                    end
                end else if (to_hit) begin
                    fail      = 1'b1;
                    fail_code = 2'b01;
                end
            end
            S_RESP: begin
                if (rx_valid) begin
                    if (rx_data == 8'hFA) begin
                        if (!sel_q) begin
                            sel_d    = 1'b1;
                            retry_d  = '0;
                            clk_dl_d = 1'b1;
                            state_d  = S_INHIBIT;
                        end else begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end
                    end else if (rx_data == 8'hFE && retry_q < RET_MAX) begin
                        retry_d  = retry_q + 1'b1;
                        clk_dl_d = 1'b1;
                        state_d  = S_INHIBIT;
                    end else begin
                        fail      = 1'b1;
                        fail_code = 2'b11;
                    end
                end else if (to_hit) begin
                    fail      = 1'b1;
                    fail_code = 2'b01;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fail) begin
            state_d   = S_IDLE;
            clk_dl_d  = 1'b0;
            data_dl_d = 1'b0;
            busy_d    = 1'b0;
            err_d     = 1'b1;
            code_d    = fail_code;
        end

        if (state_d != state_q || (timed && fall)) begin
            cnt_d = '0;
        end else if (timed || state_q == S_INHIBIT) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
        end
    end

    assign ps2_clk_drive_low  = clk_dl_q;
    assign ps2_data_drive_low = data_dl_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign err                = err_q;
    assign err_code           = code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model, PS/2 device model that clocks
// frames in and answers, and a scoreboard of expected frames and outcomes.
module tb_ps2_host_tx;

    localparam int INH = 5000;
    localparam int TO  = 2000;
    localparam int RET = 2;
    localparam int HP  = 10;
    localparam logic [3:0] R_DONE = 4'b1000;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic [15:0] ps2_pkt_HD = '0;
    logic        send_ps2_pkt = 1'b0;
    logic        ps2_clk_in, ps2_data_in;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        ps2_clk_drive_low, ps2_data_drive_low;
    logic        busy, done, err;
    logic [1:0]  err_code;

    logic        dev_clk = 1'b1;
    logic        dev_data = 1'b1;

    assign ps2_clk_in  = ps2_clk_drive_low ? 1'b0 : dev_clk;
    assign ps2_data_in = ps2_data_drive_low ? 1'b0 : dev_data;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .MAX_RETRY(RET)
    ) dut (
        .clk(clk),
        .rst_b(rst_b),
        .ps2_pkt_HD(ps2_pkt_HD),
        .send_ps2_pkt(send_ps2_pkt),
        .ps2_clk_in(ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .ps2_clk_drive_low(ps2_clk_drive_low),
        .ps2_data_drive_low(ps2_data_drive_low),
        .busy(busy),
        .done(done),
        .err(err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic [3:0] val;
        int         at;
        logic [1:0] lines;
        logic       bsy;
    } ev_t;

    exp_t sb[$];
    ev_t  evq[$];
    int   n_chk = 0;
    int   n_fail = 0;
    logic [1:0] last_code = 2'b00;

    // Every done/err pulse is logged with the line state seen alongside it.
    always @(negedge clk) begin
        if (done || err) begin
            ev_t e;
            e.val   = {done, err, err_code};
            e.at    = cyc;
            e.lines = {ps2_clk_drive_low, ps2_data_drive_low};
            e.bsy   = busy;
            evq.push_back(e);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input string tag, input logic [31:0] got,
                          output logic [31:0] exp);
        exp_t e;
        exp = '0;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s scoreboard empty got=%0h", tag, got);
        end else begin
            e = sb.pop_front();
            exp = e.val;
            chk({tag, "/", e.tag}, got, e.val);
        end
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0), b, 1'b0};
    endfunction

    task automatic push_byte(input logic [7:0] b);
        sb_push("inh", INH);
        sb_push("frame", 32'(frame_of(b)));
    endtask

    task automatic push_err(input logic [1:0] c);
        sb_push("result", {28'd0, 2'b01, c});
        last_code = c;
    endtask

    task automatic send(input logic [15:0] p, input bit chk_busy);
        @(negedge clk);
        ps2_pkt_HD   = p;
        send_ps2_pkt = 1'b1;
        @(negedge clk);
        send_ps2_pkt = 1'b0;
        if (chk_busy) chk("busy_on", 32'(busy), 1);
    endtask

    // Device side: measure the inhibit, then clock nfall edges sampling data.
    task automatic dev_xfer(input int nfall, input bit ack, output int inh,
                            output logic [10:0] fr, output int last_fall);
        int n;
        inh = 0;
        fr = '1;
        last_fall = 0;
        n = 0;
        while (!ps2_clk_drive_low && n < 200) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (ps2_clk_drive_low && !ps2_data_drive_low && n < 20000) begin
            inh++;
            @(negedge clk);
            n++;
        end
        n = 0;
        while (ps2_clk_drive_low && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (HP) @(negedge clk);
        fr[0] = ps2_data_in;
        for (int i = 1; i <= nfall; i++) begin
            if (i == 11) begin
                dev_data = ~ack;
                repeat (HP) @(negedge clk);
            end
            @(negedge clk);
            dev_clk = 1'b0;
            last_fall = cyc;
            repeat (HP) @(negedge clk);
            if (i <= 10) fr[i] = ps2_data_in;
            dev_clk = 1'b1;
            repeat (HP) @(negedge clk);
        end
        dev_data = 1'b1;
    endtask

    task automatic send_resp(input logic [7:0] b);
        repeat (20) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic byte_xfer(input logic [7:0] resp);
        int inh, lf;
        logic [10:0] fr;
        logic [31:0] x;
        dev_xfer(11, 1'b1, inh, fr, lf);
        sb_pop("inh", inh, x);
        sb_pop("frame", 32'(fr), x);
        send_resp(resp);
    endtask

    task automatic wait_result(input int bound, output int at);
        int n;
        ev_t e;
        logic [31:0] x;
        n = 0;
        at = 0;
        while (evq.size() == 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (evq.size() == 0) begin
            sb_pop("result", 0, x);
        end else begin
            e = evq.pop_front();
            at = e.at;
            sb_pop("result", 32'(e.val), x);
            chk("released", 32'(e.lines), 0);
            chk("busy_off", 32'(e.bsy), 0);
        end
        repeat (3) @(negedge clk);
        chk("extra_pulse", evq.size(), 0);
        chk("code_hold", 32'(err_code), 32'(last_code));
    endtask

    task automatic run_normal();
        int at;
        push_byte(8'hF3);
        push_byte(8'h00);
        sb_push("result", R_DONE);
        send(16'hF300, 1'b1);
        byte_xfer(8'hFA);
        byte_xfer(8'hFA);
        wait_result(100, at);
    endtask

    initial begin
        int at, inh, lf;
        logic [10:0] fr;
        logic [31:0] x;

        repeat (3) @(negedge clk);
        chk("rst_outs", {ps2_clk_drive_low, ps2_data_drive_low, busy,
                         done, err, err_code}, 0);
        rst_b = 1'b1;
        repeat (5) @(negedge clk);

        run_normal();

        push_byte(8'hF3);
        push_byte(8'hF3);
        push_byte(8'h00);
        sb_push("result", R_DONE);
        send(16'hF300, 1'b1);
        byte_xfer(8'hFE);
        byte_xfer(8'hFA);
        byte_xfer(8'hFA);
        wait_result(100, at);

        for (int i = 0; i < 3; i++) push_byte(8'hF3);
        push_err(2'b11);
        send(16'hF300, 1'b1);
        for (int i = 0; i < 3; i++) byte_xfer(8'hFE);
        wait_result(100, at);

        push_byte(8'hF3);
        push_err(2'b10);
        sb_push("lack_lat", 3);
        send(16'hF3AA, 1'b1);
        dev_xfer(11, 1'b0, inh, fr, lf);
        sb_pop("inh", inh, x);
        sb_pop("frame", 32'(fr), x);
        wait_result(20, at);
        sb_pop("lack_lat", at - lf, x);

        sb_push("inh", INH);
        sb_push("frame", 32'(frame_of(8'h5A) & 11'h03F));
        push_err(2'b01);
        sb_push("to_lat", TO + 3);
        send(16'h5AC3, 1'b1);
        fork
            dev_xfer(5, 1'b1, inh, fr, lf);
            begin
                repeat (300) @(negedge clk);
                send(16'h00FF, 1'b0);
            end
        join
        sb_pop("inh", inh, x);
        sb_pop("frame", 32'(fr & 11'h03F), x);
        wait_result(TO + 100, at);
        sb_pop("to_lat", at - lf, x);

        send(16'h1234, 1'b1);
        dev_xfer(3, 1'b1, inh, fr, lf);
        chk("pre_rst_data", 32'(ps2_data_drive_low), 1);
        #2 rst_b = 1'b0;
        #1;
        chk("arst_clk_dl", 32'(ps2_clk_drive_low), 0);
        chk("arst_data_dl", 32'(ps2_data_drive_low), 0);
        chk("arst_busy", 32'(busy), 0);
        last_code = 2'b00;
        @(negedge clk);
        rst_b = 1'b1;
        repeat (5) @(negedge clk);
        run_normal();

        chk("sb_left", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

endmodule
